// File: rtl/uart_receiver_if.sv
// Byte handshake between the UART receiver and its consumer.
// master drives valid/data_rcvd, slave drives ready.
interface uart_receiver_if;
  logic       valid;
  logic       ready;
  logic [7:0] data_rcvd;

  modport master (
    output valid,
    output data_rcvd,
    input  ready
  );

  modport slave (
    input  valid,
    input  data_rcvd,
    output ready
  );
endinterface

// File: rtl/uart_receiver.sv
// 16x-oversampled 8N1 UART receiver with valid/ready byte output.
// Ports: uart_samplig_clk, reset (sync, high), RsRx serial in,
//        rx_o (valid/ready/data_rcvd), frame_err and overrun pulses.
module uart_receiver (
  input  logic           uart_samplig_clk,
  input  logic           reset,
  input  logic           RsRx,
  uart_receiver_if.master rx_o,
  output logic           frame_err,
  output logic           overrun
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t     state_q;
  logic       meta_q;
  logic       rx_s_q;
  logic [3:0] clk_count_q;
  logic [3:0] bit_count_q;
  logic [7:0] shift_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic       ferr_q;
  logic       ovr_q;

  always_ff @(posedge uart_samplig_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      meta_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      clk_count_q <= 4'd0;
      bit_count_q <= 4'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      meta_q <= RsRx;
      rx_s_q <= meta_q;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;

      if (valid_q && rx_o.ready)
        valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          clk_count_q <= 4'd0;
          bit_count_q <= 4'd0;
          if (!rx_s_q)
            state_q <= START;
        end

        // mid-start-bit recheck filters glitches
        START: begin
          clk_count_q <= clk_count_q + 4'd1;
          if (clk_count_q == 4'd7) begin
            clk_count_q <= 4'd0;
            state_q     <= rx_s_q ? IDLE : DATA;
          end
        end

        // LSB arrives first, so shift in at the top
        DATA: begin
          clk_count_q <= clk_count_q + 4'd1;
          if (clk_count_q == 4'd15) begin
            shift_q     <= {rx_s_q, shift_q[7:1]};
            bit_count_q <= bit_count_q + 4'd1;
            if (bit_count_q == 4'd7)
              state_q <= STOP;
          end
        end

        // a same-cycle accept frees the slot, so no overrun
        STOP: begin
          clk_count_q <= clk_count_q + 4'd1;
          if (clk_count_q == 4'd15) begin
            if (rx_s_q) begin
              if (!valid_q || rx_o.ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_IDLE;
            end
          end
        end

        // stay out of START while the line is held low
        WAIT_IDLE: begin
          clk_count_q <= 4'd0;
          if (rx_s_q)
            state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_o.valid     = valid_q;
  assign rx_o.data_rcvd = data_q;
  assign frame_err      = ferr_q;
  assign overrun        = ovr_q;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

UART receive path that pairs with the team's 16x-oversampled UART transmitter: it recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the serial line and presents each byte on a valid/ready handshake. It runs on the same 16x sampling clock as the transmitter, sits between the board RX pin and the byte consumer, and flags framing errors and overruns.

## Interface
- Parameters: none. The oversample ratio is fixed at 16 and the frame format at 8N1.
- `uart_samplig_clk` in 1: 16x bit-rate sampling clock, the only clock.
- `reset` in 1: synchronous, active-high reset.
- `RsRx` in 1: asynchronous serial input; idle high.
- `valid` out 1: `data_rcvd` holds an unconsumed byte.
- `ready` in 1: consumer accepts the byte on a cycle where `valid && ready`.
- `data_rcvd` out 8: received byte; stable while `valid` is high.
- `frame_err` out 1: one-cycle pulse when a stop bit samples 0.
- `overrun` out 1: one-cycle pulse when a good frame completes while `valid` is still high.

## Operation
- Input synchronizer: two flops, `RsRx` -> `rx_s`. Reset value is 1. All decisions use `rx_s`.
- Counters:
  - `clk_count` is 4 bits and wraps 15 -> 0.
  - `bit_count` is 4 bits, range 0..8.
  - A shift register collects the data bits LSB-first.
- States:
  - IDLE: hold `clk_count=0` and `bit_count=0`. When `rx_s==0`, go to START.
  - START: increment `clk_count`.
    - At `clk_count==7`: if `rx_s==0`, clear `clk_count` and go to DATA.
    - Otherwise it is a false start (glitch): return to IDLE with nothing reported.
  - DATA: increment `clk_count`. At `clk_count==15`:
    - Shift `rx_s` in as bit `bit_count` and increment `bit_count`.
    - After bit 7, go to STOP.
  - STOP: increment `clk_count`. At `clk_count==15`, sample `rx_s`:
    - 1 and `valid==0`: load `data_rcvd`, set `valid`, go to IDLE.
    - 1 and `valid==1`: keep the old byte and `valid`, pulse `overrun`, go to IDLE. The new byte is dropped.
    - 0: pulse `frame_err`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s==1`, then go to IDLE. This prevents re-triggering on a break or held-low line.
- Handshake:
  - `valid` clears on the cycle after `valid && ready`.
  - `ready` is ignored while `valid==0`.
  - The receiver never stalls the line; reception continues regardless of `ready`.
- Simultaneous events: if the consumer accepts (`valid && ready`) on the same cycle the stop bit is sampled good, the new byte loads, `valid` stays 1, and there is no overrun.
- Reset mid-frame:
  - State goes to IDLE and the counters clear.
  - `valid=0`, `data_rcvd=8'h00`, `frame_err=0`, `overrun=0`.
  - The synchronizer flops go to 1.
  - A partial frame is lost. A line still low after reset is treated as a new start edge.

## Timing
- Let t0 be the first cycle IDLE sees `rx_s==0`. The pin falling edge precedes t0 by 2–3 cycles because of the synchronizer.
- Start-bit check at t0+8 (mid-bit).
- Data bit i is sampled at t0+8+16·(i+1), for i=0..7.
- Stop bit is sampled at t0+152.
- `valid`, `frame_err` and `overrun` are registered and appear at t0+153.
- Minimum gap before the next start detect: IDLE at t0+153, so a back-to-back frame from the transmitter (stop bit 16 cycles) is caught. The next falling edge arrives at or after ~t0+160.
- Tolerates ±3 cycles of cumulative drift per frame (about ±2% baud mismatch).
- All outputs change only on rising `uart_samplig_clk`. There is no combinational path from input to output.

## Test plan
- Single frame 0xA5 (0b10100101) at 16 clk/bit with `ready=1` -> `valid` high for exactly 1 cycle at t0+153, `data_rcvd=8'hA5`, `frame_err=0`.
- Loopback from the team's UART transmitter: send 0x00, 0xFF, 0x55, 0x3C back-to-back with `ready=1` -> four bytes received in order, no errors.
- Glitch: `RsRx` low for 4 cycles, then high -> no `valid`, state returns to IDLE; a following 0x81 frame is received correctly.
- Stop bit forced 0 on 0x7E -> `frame_err` pulses once at t0+153, `valid` stays 0. With the line held low 40 more cycles then high, no spurious frame; the next frame 0x12 is received correctly.
- `ready=0`, send 0x11 then 0x22 -> `valid=1` with `data_rcvd=8'h11`, `overrun` pulses at the end of the second frame. Raising `ready` then consumes 0x11 and `valid` drops the next cycle.
- Assert `reset` for 1 cycle at data bit 3 of a frame -> all outputs go to their reset values next cycle, and no byte from that frame is delivered.
